font_loader: RTL and testbench

FONT_LOADER -- requirements
Module: font_loader

---
 rtl/font_pkg.sv | 37 +++
 rtl/font_glyph_assembler.sv | 63 ++++++
 rtl/font_loader.sv | 165 ++++++++++++++++
 tb/tb_font_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/font_pkg.sv
// Shared types and constants for the font loader.
//   CODE_POINT_W        : width of a code-point byte
//   GLYPH_ROW_W         : width of one glyph row (one byte, MSB = leftmost pixel)
//   GLYPH_COUNT_W       : width of the saturating written-glyph counter
//   font_loader_state_t : loader FSM states; CHECK/CHECK_EVAL exist only when
//                         FONT_LOADER_CHECKSUM_EN is defined
//   sat_inc             : saturating increment for the glyph counter
package font_pkg;

    localparam int CODE_POINT_W  = 8;
    localparam int GLYPH_ROW_W   = 8;
    localparam int GLYPH_COUNT_W = 9;

`ifdef FONT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CHECK,
        CHECK_EVAL,
        WRITE
    } font_loader_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        WRITE
    } font_loader_state_t;
`endif

    function automatic logic [GLYPH_COUNT_W-1:0] sat_inc(input logic [GLYPH_COUNT_W-1:0] value);
        if (value == {GLYPH_COUNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/font_glyph_assembler.sv
// Collects glyph rows into a bitmap, one byte per row.
//   clk        : clock (rising edge)
//   srst       : synchronous active-high reset, clears rows and counter
//   clear      : restart at row 0 (new packet or abort)
//   load       : store row_byte into the row addressed by the counter
//   row_byte   : incoming row byte
//   last_row   : the counter addresses the final row
//   glyph_next : bitmap including a row being loaded this cycle, so the
//                caller can capture a complete glyph on the same edge that
//                stores the last row. Row r sits at
//                [GLYPH_ROW_W*(GLYPH_HEIGHT-r)-1 -: GLYPH_ROW_W].
module font_glyph_assembler
    import font_pkg::*;
#(
    parameter int GLYPH_HEIGHT = 16
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic                                clear,
    input  logic                                load,
    input  logic [GLYPH_ROW_W-1:0]              row_byte,
    output logic                                last_row,
    output logic [GLYPH_ROW_W*GLYPH_HEIGHT-1:0] glyph_next
);

    localparam int CNT_W = $clog2(GLYPH_HEIGHT + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign last_row = (count_reg == CNT_W'(GLYPH_HEIGHT - 1));

    generate
        for (genvar gi = 0; gi < GLYPH_HEIGHT; gi++) begin : g_row
            logic                   hit;
            logic [GLYPH_ROW_W-1:0] row_reg;

            assign hit = load && (count_reg == CNT_W'(gi));

            always_ff @(posedge clk) begin
                if (srst) begin
                    row_reg <= '0;
                end else if (hit) begin
                    row_reg <= row_byte;
                end
            end

            // Row 0 lands in the most significant byte.
            assign glyph_next[GLYPH_ROW_W*(GLYPH_HEIGHT-gi)-1 -: GLYPH_ROW_W] =
                hit ? row_byte : row_reg;
        end
    endgenerate

endmodule

// File: rtl/font_loader.sv
// Streams glyph packets into a font RAM write port.
// Packet: code-point byte, GLYPH_HEIGHT row bytes (row 0 first), and a
// checksum byte when FONT_LOADER_CHECKSUM_EN is defined (XOR of code point
// and all rows; a mismatch drops the glyph and sets a sticky error).
//   clk_hdmi_in     : clock (rising edge)
//   rst_in          : synchronous active-high reset
//   byte_valid_in   : stream byte offered
//   byte_in         : stream byte
//   byte_ready_out  : byte accepted this cycle when valid
//   abort_in        : discard any partial glyph, return to IDLE
//   wr_en_out       : one-cycle font RAM write strobe
//   wr_addr_out     : code point being written (held between writes)
//   wr_data_out     : glyph bitmap (held between writes)
//   busy_out        : FSM not in IDLE
//   glyph_count_out : glyphs written since reset, saturating at 9'h1FF
//   error_out       : sticky checksum failure (0 without the macro)
module font_loader
    import font_pkg::*;
#(
    parameter int GLYPH_HEIGHT = 16
) (
    input  logic                                clk_hdmi_in,
    input  logic                                rst_in,
    input  logic                                byte_valid_in,
    input  logic [7:0]                          byte_in,
    output logic                                byte_ready_out,
    input  logic                                abort_in,
    output logic                                wr_en_out,
    output logic [7:0]                          wr_addr_out,
    output logic [8*GLYPH_HEIGHT-1:0]           wr_data_out,
    output logic                                busy_out,
    output logic [8:0]                          glyph_count_out,
    output logic                                error_out
);

    localparam int DATA_W = GLYPH_ROW_W * GLYPH_HEIGHT;

    font_loader_state_t         state_reg;
    logic [CODE_POINT_W-1:0]    code_reg;
    logic                       wr_en_reg;
    logic [CODE_POINT_W-1:0]    wr_addr_reg;
    logic [DATA_W-1:0]          wr_data_reg;
    logic [GLYPH_COUNT_W-1:0]   count_reg;

    logic                       accept;
    logic                       asm_clear;
    logic                       asm_load;
    logic                       last_row;
    logic [DATA_W-1:0]          glyph_next;

`ifdef FONT_LOADER_CHECKSUM_EN
    logic [7:0]                 xor_reg;
    logic [7:0]                 chk_reg;
    logic                       error_reg;

    assign byte_ready_out = (state_reg != WRITE) && (state_reg != CHECK_EVAL) && !abort_in;
    assign error_out      = error_reg;
`else
    assign byte_ready_out = (state_reg != WRITE) && !abort_in;
    assign error_out      = 1'b0;
`endif

    assign accept    = byte_valid_in && byte_ready_out;
    assign asm_clear = abort_in || ((state_reg == IDLE) && accept);
    assign asm_load  = (state_reg == DATA) && accept;

    font_glyph_assembler #(
        .GLYPH_HEIGHT (GLYPH_HEIGHT)
    ) u_assembler (
        .clk        (clk_hdmi_in),
        .srst       (rst_in),
        .clear      (asm_clear),
        .load       (asm_load),
        .row_byte   (byte_in),
        .last_row   (last_row),
        .glyph_next (glyph_next)
    );

    // Write outputs are loaded on the edge that enters WRITE, so the strobe,
    // address, data and updated count are all valid during the WRITE cycle.
    always_ff @(posedge clk_hdmi_in) begin
        if (rst_in) begin
            state_reg   <= IDLE;
            code_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            count_reg   <= '0;
`ifdef FONT_LOADER_CHECKSUM_EN
            xor_reg     <= '0;
            chk_reg     <= '0;
            error_reg   <= 1'b0;
`endif
        end else begin
            wr_en_reg <= 1'b0;
            if (abort_in) begin
                // A strobe already in flight (WRITE) completes on its own.
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            code_reg  <= byte_in;
                            state_reg <= DATA;
`ifdef FONT_LOADER_CHECKSUM_EN
                            xor_reg   <= byte_in;
`endif
                        end
                    end
                    DATA: begin
                        if (accept) begin
`ifdef FONT_LOADER_CHECKSUM_EN
                            xor_reg <= xor_reg ^ byte_in;
                            if (last_row) begin
                                state_reg <= CHECK;
                            end
`else
                            if (last_row) begin
                                state_reg   <= WRITE;
                                wr_en_reg   <= 1'b1;
                                wr_addr_reg <= code_reg;
                                wr_data_reg <= glyph_next;
                                count_reg   <= sat_inc(count_reg);
                            end
`endif
                        end
                    end
`ifdef FONT_LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (accept) begin
                            chk_reg   <= byte_in;
                            state_reg <= CHECK_EVAL;
                        end
                    end
                    CHECK_EVAL: begin
                        if (chk_reg == xor_reg) begin
                            state_reg   <= WRITE;
                            wr_en_reg   <= 1'b1;
                            wr_addr_reg <= code_reg;
                            wr_data_reg <= glyph_next;
                            count_reg   <= sat_inc(count_reg);
                        end else begin
                            state_reg <= IDLE;
                            error_reg <= 1'b1;
                        end
                    end
`endif
                    WRITE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_en_out       = wr_en_reg;
    assign wr_addr_out     = wr_addr_reg;
    assign wr_data_out     = wr_data_reg;
    assign glyph_count_out = count_reg;
    assign busy_out        = (state_reg != IDLE);

endmodule

// File: tb/tb_font_loader.sv
// Self-checking bench for font_loader (default GLYPH_HEIGHT = 16).
// Works with and without FONT_LOADER_CHECKSUM_EN defined.
module tb_font_loader;

    localparam int GH = 16;
    localparam int DW = 8 * GH;
`ifdef FONT_LOADER_CHECKSUM_EN
    localparam int NBYTES = GH + 2;
`else
    localparam int NBYTES = GH + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_in = 1'b1;
    logic            byte_valid_in = 1'b0;
    logic [7:0]      byte_in = '0;
    logic            byte_ready_out;
    logic            abort_in = 1'b0;
    logic            wr_en_out;
    logic [7:0]      wr_addr_out;
    logic [DW-1:0]   wr_data_out;
    logic            busy_out;
    logic [8:0]      glyph_count_out;
    logic            error_out;

    int checks = 0;
    int errors = 0;
    int strobe_count = 0;

    // Reference state
    int            exp_writes = 0;
    int            exp_count = 0;
    logic [7:0]    last_addr = '0;
    logic [DW-1:0] last_data = '0;

    // Current packet
    logic [7:0] pkt_code;
    logic [7:0] pkt_rows [GH];
    logic [7:0] pkt_chk;

    font_loader #(.GLYPH_HEIGHT(GH)) dut (
        .clk_hdmi_in     (clk),
        .rst_in          (rst_in),
        .byte_valid_in   (byte_valid_in),
        .byte_in         (byte_in),
        .byte_ready_out  (byte_ready_out),
        .abort_in        (abort_in),
        .wr_en_out       (wr_en_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out),
        .glyph_count_out (glyph_count_out),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en_out === 1'b1) strobe_count <= strobe_count + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row 0 is the leftmost (most significant) byte of the bitmap.
    function automatic logic [DW-1:0] pack_rows();
        logic [DW-1:0] acc;
        acc = '0;
        for (int r = 0; r < GH; r++) acc = (acc << 8) | DW'(pkt_rows[r]);
        return acc;
    endfunction

    function automatic logic [7:0] good_chk();
        logic [7:0] x;
        x = pkt_code;
        for (int r = 0; r < GH; r++) x = x ^ pkt_rows[r];
        return x;
    endfunction

    task automatic fill_rows(input int kind, input logic [7:0] code);
        pkt_code = code;
        for (int r = 0; r < GH; r++) begin
            case (kind)
                0: pkt_rows[r] = 8'(r);
                1: pkt_rows[r] = 8'hFF;
                2: pkt_rows[r] = 8'h00;
                default: pkt_rows[r] = 8'($urandom_range(0, 255));
            endcase
        end
        pkt_chk = good_chk();
    endtask

    // gap_mode: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps
    task automatic send_bytes(input int n, input int gap_mode);
        logic [7:0] seq[$];
        bit phase;
        bit done;
        int tries;
        phase = 1'b1;
        seq.push_back(pkt_code);
        for (int r = 0; r < GH; r++) seq.push_back(pkt_rows[r]);
`ifdef FONT_LOADER_CHECKSUM_EN
        seq.push_back(pkt_chk);
`endif
        for (int i = 0; i < n; i++) begin
            done = 1'b0;
            tries = 0;
            while (!done) begin
                @(negedge clk);
                case (gap_mode)
                    0: byte_valid_in = 1'b1;
                    1: begin byte_valid_in = phase; phase = ~phase; end
                    default: byte_valid_in = ($urandom_range(0, 3) != 0);
                endcase
                byte_in = seq[i];
                #1;
                if (byte_valid_in) check("ready_when_offered", DW'(byte_ready_out), DW'(1));
                done = byte_valid_in && byte_ready_out;
                tries++;
                if (!done && tries > 20) begin
                    $display("FAIL byte_timeout observed=ready_low expected=accept_within_20");
                    $fatal(1, "byte handshake timeout");
                end
            end
        end
        @(negedge clk);
        byte_valid_in = 1'b0;
    endtask

    task automatic send_packet(input int gap_mode, input bit expect_write);
        logic [DW-1:0] exp_data;
        exp_data = pack_rows();
        send_bytes(NBYTES, gap_mode);
        #1;
`ifdef FONT_LOADER_CHECKSUM_EN
        check("eval_no_strobe", DW'(wr_en_out), DW'(0));
        check("eval_ready_low", DW'(byte_ready_out), DW'(0));
        @(negedge clk);
        #1;
`endif
        if (expect_write) begin
            check("strobe", DW'(wr_en_out), DW'(1));
            check("write_ready_low", DW'(byte_ready_out), DW'(0));
            check("wr_addr", DW'(wr_addr_out), DW'(pkt_code));
            check("wr_data", wr_data_out, exp_data);
            exp_writes++;
            if (exp_count < 511) exp_count++;
            last_addr = pkt_code;
            last_data = exp_data;
            @(negedge clk);
            #1;
            check("strobe_one_cycle", DW'(wr_en_out), DW'(0));
            check("glyph_count", DW'(glyph_count_out), DW'(exp_count));
            check("addr_hold", DW'(wr_addr_out), DW'(last_addr));
            check("data_hold", wr_data_out, last_data);
        end else begin
            check("no_strobe_bad_chk", DW'(wr_en_out), DW'(0));
            check("error_set", DW'(error_out), DW'(1));
            @(negedge clk);
            #1;
        end
        check("strobe_total", DW'(strobe_count), DW'(exp_writes));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_en", DW'(wr_en_out), DW'(0));
        check("rst_addr", DW'(wr_addr_out), DW'(0));
        check("rst_data", wr_data_out, DW'(0));
        check("rst_count", DW'(glyph_count_out), DW'(0));
        check("rst_error", DW'(error_out), DW'(0));
        check("rst_busy", DW'(busy_out), DW'(0));
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        check("ready_after_rst", DW'(byte_ready_out), DW'(1));

        // Incrementing rows, code point 41, no gaps
        fill_rows(0, 8'h41);
        send_packet(0, 1'b1);
        check("req038_data", wr_data_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("req038_count", DW'(glyph_count_out), DW'(1));

        // Same packet with valid toggling every other cycle
        send_packet(1, 1'b1);

        // Abort after 5 row bytes, then an all-ones glyph at 7F
        fill_rows(3, 8'h22);
        send_bytes(6, 0);
        abort_in = 1'b1;
        #1;
        check("abort_ready_low", DW'(byte_ready_out), DW'(0));
        @(negedge clk);
        abort_in = 1'b0;
        #1;
        check("abort_idle", DW'(busy_out), DW'(0));
        fill_rows(1, 8'h7F);
        send_packet(0, 1'b1);
        check("abort_data_ones", wr_data_out, {DW{1'b1}});

        // Reset after 10 row bytes
        fill_rows(3, 8'h33);
        send_bytes(11, 0);
        rst_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrst_wr_en", DW'(wr_en_out), DW'(0));
        check("midrst_addr", DW'(wr_addr_out), DW'(0));
        check("midrst_data", wr_data_out, DW'(0));
        check("midrst_count", DW'(glyph_count_out), DW'(0));
        check("midrst_no_strobe", DW'(strobe_count), DW'(exp_writes));
        exp_count = 0;
        rst_in = 1'b0;
        #1;
        check("midrst_ready", DW'(byte_ready_out), DW'(1));
        fill_rows(3, 8'hFF);
        send_packet(2, 1'b1);

`ifdef FONT_LOADER_CHECKSUM_EN
        // Checksum pass and fail
        fill_rows(2, 8'h01);
        check("chk_model", DW'(pkt_chk), DW'(8'h01));
        send_packet(0, 1'b1);
        pkt_chk = 8'h00;
        send_packet(0, 1'b0);
        fill_rows(3, 8'h55);
        send_packet(0, 1'b1);
        check("error_sticky", DW'(error_out), DW'(1));
`else
        check("error_tied", DW'(error_out), DW'(0));
`endif

        // Long random run to saturate the glyph counter
        for (int p = 0; p < 512; p++) begin
            fill_rows((p % 7 == 0) ? 2 : 3, (p % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            send_packet(2, 1'b1);
        end
        check("count_saturated", DW'(glyph_count_out), DW'(9'h1FF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
